regfile_reader: RTL and testbench

Read-side client for the tile register file. On a start request it asserts the register file's read enable, waits for the register file's read-valid, captures the full read vector (both input banks plus the scalar register) into a local snapshot buffer, and streams the words out one per handshake on a valid/ready port. It sits between the tile regfile and the tile's outbound routing/debug path, and it flags a timeout if the regfile never answers.

---
 rtl/regfile_reader.sv | 120 ++++++++++++
 tb/tb_regfile_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_reader.sv
// Read-side client for the tile register file: requests one read, snapshots the
// full read vector, then streams it out word by word on a valid/ready port.

module regfile_reader_word #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    q <= '0;
        else if (cap) q <= d;
    end
endmodule

module regfile_reader #(
    parameter int width      = 16,
    parameter int num_inputs = 4,
    parameter int timeout    = 15
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 ren,
    input  logic [width-1:0]                     r_data [2*num_inputs+1],
    input  logic                                 r_data_vld,
    output logic [width-1:0]                     out_data,
    output logic [$clog2(2*num_inputs+1)-1:0]    out_idx,
    output logic                                 out_vld,
    input  logic                                 out_rdy,
    output logic                                 out_last,
    output logic                                 done,
    output logic                                 timeout_err
);
    localparam int num_words = 2*num_inputs + 1;
    localparam int iw        = $clog2(num_words);
    localparam int cw        = $clog2(timeout + 1);
    localparam logic [iw-1:0] last_idx = iw'(num_words - 1);
    localparam logic [cw-1:0] wait_max = cw'(timeout - 1);

    typedef enum logic [1:0] {IDLE, REQ, STREAM} state_t;
    state_t state, state_nxt;

    logic [width-1:0] snap [num_words];
    logic [cw-1:0]    wait_cnt;
    logic [iw-1:0]    idx_nxt;
    logic             capture, advance;

    // Snapshot buffer: one capture register per regfile word.
    for (genvar g = 0; g < num_words; g++) begin : g_word
        regfile_reader_word #(.width(width)) u_word (
            .clk   (clk),
            .reset (reset),
            .cap   (capture),
            .d     (r_data[g]),
            .q     (snap[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (r_data_vld)            state_nxt = STREAM;
                     else if (wait_cnt == wait_max) state_nxt = IDLE;
            STREAM:  if (out_vld && out_rdy && out_idx == last_idx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture  = (state == REQ) && r_data_vld;
        advance  = (state == STREAM) && out_vld && out_rdy;
        out_last = out_vld && (out_idx == last_idx);
        idx_nxt  = out_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            ren         <= 1'b0;
            out_vld     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            out_idx     <= '0;
            out_data    <= '0;
        end else begin
            busy    <= (state_nxt != IDLE);
            ren     <= (state_nxt == REQ);
            out_vld <= (state_nxt == STREAM);
            done    <= advance && out_last;

            if (state == IDLE && start) begin
                wait_cnt    <= '0;
                timeout_err <= 1'b0;
            end else if (state == REQ && !r_data_vld) begin
                if (wait_cnt == wait_max)  timeout_err <= 1'b1;
                else if (wait_cnt != '1)   wait_cnt    <= wait_cnt + 1'b1;  // saturate, never wrap
            end

            if (capture) begin
                out_idx  <= '0;
                out_data <= r_data[0];
            end else if (advance && !out_last) begin
                out_idx  <= idx_nxt;
                out_data <= snap[idx_nxt];
            end
        end
    end
endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: transaction-level model plus per-cycle compare.

module tb_regfile_reader;
    localparam int W   = 16;
    localparam int NI  = 4;
    localparam int NW  = 2*NI + 1;
    localparam int TMO = 15;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, r_data_vld = 1'b0, out_rdy = 1'b1;
    logic [W-1:0]  r_data [NW];
    logic          busy, ren, out_vld, out_last, done, timeout_err;
    logic [W-1:0]  out_data;
    logic [3:0]    out_idx;

    int n_cmp = 0, n_bad = 0;
    int rdy_mode = 0;
    bit chg = 0;

    logic [W-1:0] base_d [NW] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h6666,
                                  16'h7777, 16'h8888, 16'h9999, 16'hBBBB};

    regfile_reader #(.width(W), .num_inputs(NI), .timeout(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .ren(ren),
        .r_data(r_data), .r_data_vld(r_data_vld), .out_data(out_data), .out_idx(out_idx),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 waiting on regfile, 2 streaming.
    int           m_phase = 0, m_wait = 0, m_idx = 0;
    bit           m_done = 0, m_err = 0;
    logic [W-1:0] m_snap [NW];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_wait <= 0; m_idx <= 0; m_done <= 0; m_err <= 0;
        end else begin
            m_done <= 0;
            case (m_phase)
                0: if (start) begin m_phase <= 1; m_wait <= 1; m_err <= 0; end
                1: if (r_data_vld) begin m_snap <= r_data; m_idx <= 0; m_phase <= 2; end
                   else if (m_wait == TMO) begin m_phase <= 0; m_err <= 1; end
                   else m_wait <= m_wait + 1;
                default: if (out_rdy) begin
                       if (m_idx == NW-1) begin m_phase <= 0; m_done <= 1; end
                       else m_idx <= m_idx + 1;
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("ren", {31'b0, ren}, {31'b0, m_phase == 1});
        chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
        chk("out_vld", {31'b0, out_vld}, {31'b0, m_phase == 2});
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("timeout_err", {31'b0, timeout_err}, {31'b0, m_err});
        if (m_phase == 2) begin
            chk("out_data", {16'b0, out_data}, {16'b0, m_snap[m_idx]});
            chk("out_idx", {28'b0, out_idx}, m_idx);
            chk("out_last", {31'b0, out_last}, {31'b0, m_idx == NW-1});
        end else begin
            chk("out_last_idle", {31'b0, out_last}, 32'd0);
        end
    end

    // Monitor: handshakes and event counts for the literal checks.
    logic [W-1:0] got [$];
    int           got_idx [$];
    bit           got_last [$];
    int           ren_cnt = 0, ren_rise = 0, vld_cnt = 0, done_cnt = 0;
    bit           ren_q = 0;

    always @(negedge clk) begin
        if (ren) ren_cnt <= ren_cnt + 1;
        if (ren && !ren_q) ren_rise <= ren_rise + 1;
        ren_q <= ren;
        if (out_vld) vld_cnt <= vld_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (out_vld && out_rdy) begin
            got.push_back(out_data);
            got_idx.push_back(int'(out_idx));
            got_last.push_back(out_last);
        end
    end

    // Downstream ready: always 1, or the 1,0,0,1 pattern.
    initial begin
        int ph = 0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        forever begin
            @(posedge clk); #2;
            if (rdy_mode == 0) out_rdy = 1'b1;
            else begin out_rdy = pat[ph % 4]; ph++; end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic give_vld(input int dly);
        repeat (dly-1) @(posedge clk);
        #2 r_data_vld = 1'b1;
        @(posedge clk); #2 r_data_vld = 1'b0;
        if (chg) r_data[0] = 16'hCCCC;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        @(posedge clk); #2;
    endtask

    task automatic check_words(input string tag, input int b);
        chk({tag, "_count"}, got.size() - b, NW);
        for (int i = 0; i < NW && b + i < got.size(); i++) begin
            chk({tag, "_word"}, {16'b0, got[b+i]}, {16'b0, base_d[i]});
            chk({tag, "_idx"}, got_idx[b+i], i);
            chk({tag, "_last"}, {31'b0, got_last[b+i]}, {31'b0, i == NW-1});
        end
    endtask

    initial begin
        int b, r0, d0, v0;
        bit seen;
        for (int i = 0; i < NW; i++) r_data[i] = base_d[i];

        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ren", {31'b0, ren}, 32'd0);
        chk("rst_vld", {31'b0, out_vld}, 32'd0);
        chk("rst_data", {16'b0, out_data}, 32'd0);
        @(posedge clk); #2 reset = 1'b0;

        // Basic read, valid 3 cycles after ren.
        b = got.size(); r0 = ren_cnt; d0 = done_cnt;
        pulse_start();
        chk("basic_ren_up", {31'b0, ren}, 32'd1);
        give_vld(3);
        wait_done("basic");
        chk("basic_ren_cycles", ren_cnt - r0, 3);
        chk("basic_done_cycles", done_cnt - d0, 1);
        check_words("basic", b);

        // Backpressure.
        rdy_mode = 1; b = got.size();
        pulse_start(); give_vld(3); wait_done("bp");
        check_words("bp", b);
        rdy_mode = 0;

        // regfile data changes after capture.
        chg = 1; b = got.size();
        pulse_start(); give_vld(2); wait_done("chg");
        chg = 0;
        chk("chg_word0", {16'b0, got[b]}, 32'h1111);
        r_data[0] = base_d[0];

        // Timeout: no valid ever.
        r0 = ren_cnt; v0 = vld_cnt;
        pulse_start();
        repeat (20) @(posedge clk); #2;
        chk("tmo_ren_cycles", ren_cnt - r0, TMO);
        chk("tmo_err", {31'b0, timeout_err}, 32'd1);
        chk("tmo_no_vld", vld_cnt - v0, 0);
        chk("tmo_busy", {31'b0, busy}, 32'd0);
        pulse_start();
        chk("tmo_err_cleared", {31'b0, timeout_err}, 32'd0);
        give_vld(1); wait_done("after_tmo");

        // Ignored start mid-stream, then reset at out_idx 4.
        rdy_mode = 1; r0 = ren_rise;
        pulse_start(); give_vld(1);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); if (out_vld && out_idx == 2) seen = 1; end
        chk("ign_reach_idx2", {31'b0, seen}, 32'd1);
        pulse_start();
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); if (out_vld && out_idx == 4) seen = 1; end
        chk("ign_reach_idx4", {31'b0, seen}, 32'd1);
        chk("ign_ren_rises", ren_rise - r0, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_vld", {31'b0, out_vld}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_idx", {28'b0, out_idx}, 32'd0);
        chk("midrst_data", {16'b0, out_data}, 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        rdy_mode = 0;

        // Fresh capture after reset.
        for (int i = 0; i < NW; i++) r_data[i] = 16'hA000 + 16'(i);
        b = got.size();
        pulse_start(); give_vld(2); wait_done("fresh");
        chk("fresh_count", got.size() - b, NW);
        if (got.size() > b) begin
            chk("fresh_word0", {16'b0, got[b]}, 32'hA000);
            chk("fresh_idx0", got_idx[b], 0);
        end

        @(posedge clk); #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
